norm_shifter: RTL



---
 rtl/norm_shifter.sv | 94 +++++++++
 1 files changed

// File: rtl/norm_shifter.sv
// Sequential left-normalizer: shifts an accepted word left until its MSB is set
// and reports the shift count (the leading-zero count of the input word).
module norm_shifter #(
  parameter int WIDTH  = 32,
  parameter int CNT_W  = 6,
  parameter int COARSE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_zero
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] data_q, data_nx, shifted;
  logic [CNT_W-1:0] count_q, count_nx, count_step;
  logic             zero_q, zero_nx;
  logic             coarse_ok;

  // A coarse step is safe whenever the top COARSE bits are zero: the word is
  // nonzero, so at least one more step is still needed afterwards or exactly
  // this one lands the leading one in the MSB.
  assign coarse_ok  = ~|data_q[WIDTH-1 -: COARSE];
  assign shifted    = coarse_ok ? (data_q << COARSE) : (data_q << 1);
  assign count_step = coarse_ok ? CNT_W'(COARSE) : CNT_W'(1);

  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    data_nx  = data_q;
    count_nx = count_q;
    zero_nx  = zero_q;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          data_nx  = in_data;
          count_nx = '0;
          zero_nx  = 1'b0;
          if (in_data == '0) begin
            count_nx = CNT_W'(WIDTH);
            zero_nx  = 1'b1;
            state_nx = DONE;
          end else if (in_data[WIDTH-1]) begin
            state_nx = DONE;
          end else begin
            state_nx = SHIFT;
          end
        end
      end
      SHIFT: begin
        data_nx  = shifted;
        count_nx = count_q + count_step;
        if (shifted[WIDTH-1]) state_nx = DONE;
      end
      DONE: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      data_q  <= '0;
      count_q <= '0;
      zero_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      data_q  <= data_nx;
      count_q <= count_nx;
      zero_q  <= zero_nx;
    end
  end

  // Handshake flags are pure state decodes; nothing combinational from inputs.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_data  = data_q;
  assign out_count = count_q;
  assign out_zero  = zero_q;

endmodule
